// File: rtl/pin_sim_sequencer.sv
// Frame-level sequencer: per frame tick, issues STEPS_PER_FRAME collision/position substeps; settles and racks.
// Optional PIN_SEQ_TICK_QUEUE_EN: hold one frame tick that lands during stepping and replay it afterwards.
module pin_sim_sequencer #(
  parameter int unsigned STEPS_PER_FRAME = 4,
  parameter int unsigned SETTLE_FRAMES   = 180,
  parameter int unsigned TIMER_RST       = 3000000
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       frame_tick_in,
  input  logic       ball_launch_in,
  input  logic       ball_done_in,
  output logic       coll_req_out,
  input  logic       coll_valid_in,
  input  logic [9:0] coll_hit_in,
  input  logic       coll_vy_neg_in,
  output logic       pins_valid_out,
  output logic [9:0] pins_hit_out,
  output logic       pins_vy_neg_out,
  output logic       rst_sim_out,
  output logic       busy_out,
  output logic [3:0] score_out,
  output logic       overrun_out,
  output logic       err_out
);

  localparam int unsigned     WD_W        = (TIMER_RST > 2) ? $clog2(TIMER_RST) : 1;
  localparam logic [3:0]      STEP_LAST   = 4'(STEPS_PER_FRAME - 1);
  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_FRAMES);
  localparam logic [WD_W-1:0] WD_LAST     = WD_W'(TIMER_RST - 1);

  typedef enum logic [2:0] {
    IDLE,
    ROLLING,
    STEP_REQ,
    STEP_APPLY,
    SETTLE,
    RESET_RACK
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      step_cnt_q;
  logic [7:0]      settle_cnt_q;
  logic [9:0]      sticky_q;
  logic            vy_neg_q;
  logic            done_q;
  logic [3:0]      score_q;
  logic            err_q;
  logic            abort_q;
  logic            overrun_q;
  logic [WD_W-1:0] wd_cnt_q;

  logic stepping, last_step, done_eff, settle_done, wd_expire, restart_tick;

`ifdef PIN_SEQ_TICK_QUEUE_EN
  logic pend_q;
  assign restart_tick = pend_q | frame_tick_in;
`else
  assign restart_tick = 1'b0;
`endif

  function automatic logic [3:0] popcount10(input logic [9:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < 10; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  assign stepping    = (state_q == STEP_REQ) || (state_q == STEP_APPLY);
  assign last_step   = (step_cnt_q == STEP_LAST);
  assign done_eff    = done_q | ball_done_in;
  assign settle_done = done_eff && (settle_cnt_q >= SETTLE_LAST);
  assign wd_expire   = (state_q == STEP_REQ) && !coll_valid_in && (wd_cnt_q == WD_LAST);

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) state_q <= RESET_RACK;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (ball_launch_in) state_d = ROLLING;
      ROLLING: begin
        if (frame_tick_in)     state_d = STEP_REQ;
        else if (ball_done_in) state_d = SETTLE;
      end
      STEP_REQ: begin
        if (coll_valid_in)  state_d = STEP_APPLY;
        else if (wd_expire) state_d = RESET_RACK;
      end
      STEP_APPLY: begin
        if (!last_step)        state_d = STEP_REQ;
        else if (settle_done)  state_d = RESET_RACK;
        else if (restart_tick) state_d = STEP_REQ;
        else if (done_eff)     state_d = SETTLE;
        else                   state_d = ROLLING;
      end
      SETTLE:     if (frame_tick_in) state_d = STEP_REQ;
      RESET_RACK: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Later assignments in this block deliberately override earlier ones (rack clear beats done latch).
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      step_cnt_q   <= '0;
      settle_cnt_q <= '0;
      sticky_q     <= '0;
      vy_neg_q     <= 1'b0;
      done_q       <= 1'b0;
      score_q      <= '0;
      err_q        <= 1'b0;
      abort_q      <= 1'b1;
      overrun_q    <= 1'b0;
      wd_cnt_q     <= '0;
`ifdef PIN_SEQ_TICK_QUEUE_EN
      pend_q       <= 1'b0;
`endif
    end else begin
      overrun_q <= 1'b0;
      wd_cnt_q  <= ((state_q == STEP_REQ) && !coll_valid_in) ? wd_cnt_q + 1'b1 : '0;

      if (ball_done_in && (state_q != IDLE)) begin
        done_q <= 1'b1;
        if (!done_q) settle_cnt_q <= '0;
      end

      if (frame_tick_in && stepping) begin
`ifdef PIN_SEQ_TICK_QUEUE_EN
        if (pend_q) overrun_q <= 1'b1;
        else        pend_q    <= 1'b1;
`else
        overrun_q <= 1'b1;
`endif
      end

      case (state_q)
        ROLLING, SETTLE: begin
          if (frame_tick_in) begin
            step_cnt_q <= '0;
            if (state_q == SETTLE) settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        STEP_REQ: begin
          if (coll_valid_in) begin
            sticky_q <= sticky_q | coll_hit_in;
            vy_neg_q <= coll_vy_neg_in;
          end else if (wd_expire) begin
            err_q   <= 1'b1;
            abort_q <= 1'b1;
          end
        end
        STEP_APPLY: begin
          if (!last_step) begin
            step_cnt_q <= step_cnt_q + 1'b1;
          end else if (state_d == STEP_REQ) begin
            step_cnt_q <= '0;
            if (done_eff) settle_cnt_q <= settle_cnt_q + 1'b1;
`ifdef PIN_SEQ_TICK_QUEUE_EN
            pend_q <= 1'b0;
`endif
          end
        end
        RESET_RACK: begin
          score_q      <= abort_q ? 4'd0 : popcount10(sticky_q);
          sticky_q     <= '0;
          step_cnt_q   <= '0;
          settle_cnt_q <= '0;
          done_q       <= 1'b0;
          abort_q      <= 1'b0;
`ifdef PIN_SEQ_TICK_QUEUE_EN
          pend_q       <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  // Reset state is RESET_RACK, so the state-decoded strobes are gated to stay low while reset is held.
  assign rst_sim_out     = rst_in_n && (state_q == RESET_RACK);
  assign busy_out        = rst_in_n && (state_q != IDLE);
  assign coll_req_out    = (state_q == STEP_REQ);
  assign pins_valid_out  = (state_q == STEP_APPLY);
  assign pins_hit_out    = sticky_q;
  assign pins_vy_neg_out = vy_neg_q;
  assign score_out       = score_q;
  assign overrun_out     = overrun_q;
  assign err_out         = err_q;

endmodule

// File: tb/tb_pin_sim_sequencer.sv
// Bench for pin_sim_sequencer: auto-answering collision model plus a scoreboard of expected position updates.
module tb_pin_sim_sequencer;

  localparam int unsigned STEPS  = 4;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned WD     = 50;

  logic       clk_in = 1'b0;
  logic       rst_in_n;
  logic       frame_tick_in, ball_launch_in, ball_done_in;
  logic       coll_req_out, coll_valid_in, coll_vy_neg_in;
  logic [9:0] coll_hit_in;
  logic       pins_valid_out, pins_vy_neg_out, rst_sim_out, busy_out, overrun_out, err_out;
  logic [9:0] pins_hit_out;
  logic [3:0] score_out;

  int unsigned total = 0, bad = 0;
  int unsigned valid_cnt = 0, hs_cnt = 0, ovr_cnt = 0, rsim_cnt = 0;
  logic [9:0]  resp_hit = '0;
  bit          resp_en = 1'b1;
  int unsigned resp_lat = 3;
  logic [9:0]  model_sticky = '0;
  logic [10:0] exp_q[$];

  always #5 clk_in = ~clk_in;

  pin_sim_sequencer #(
    .STEPS_PER_FRAME(STEPS),
    .SETTLE_FRAMES  (SETTLE),
    .TIMER_RST      (WD)
  ) dut (
    .clk_in         (clk_in),
    .rst_in_n       (rst_in_n),
    .frame_tick_in  (frame_tick_in),
    .ball_launch_in (ball_launch_in),
    .ball_done_in   (ball_done_in),
    .coll_req_out   (coll_req_out),
    .coll_valid_in  (coll_valid_in),
    .coll_hit_in    (coll_hit_in),
    .coll_vy_neg_in (coll_vy_neg_in),
    .pins_valid_out (pins_valid_out),
    .pins_hit_out   (pins_hit_out),
    .pins_vy_neg_out(pins_vy_neg_out),
    .rst_sim_out    (rst_sim_out),
    .busy_out       (busy_out),
    .score_out      (score_out),
    .overrun_out    (overrun_out),
    .err_out        (err_out)
  );

  // Collision unit: answers resp_lat cycles after the request is first seen; pushes the expected update.
  initial begin : responder
    int unsigned cnt;
    logic        vy;
    cnt = 0;
    coll_valid_in  = 1'b0;
    coll_hit_in    = '0;
    coll_vy_neg_in = 1'b0;
    forever begin
      @(posedge clk_in); #1;
      coll_valid_in = 1'b0;
      if (coll_req_out === 1'b1 && resp_en) begin
        if (cnt == resp_lat) begin
          vy = 1'($urandom_range(0, 1));
          coll_valid_in  = 1'b1;
          coll_hit_in    = resp_hit;
          coll_vy_neg_in = vy;
          model_sticky   = model_sticky | resp_hit;
          exp_q.push_back({model_sticky, vy});
          hs_cnt++;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : monitor
    logic [10:0] e;
    forever begin
      @(posedge clk_in); #1;
      if (overrun_out === 1'b1) ovr_cnt++;
      if (rst_sim_out === 1'b1) begin
        rsim_cnt++;
        model_sticky = '0;
      end
      if (pins_valid_out === 1'b1) begin
        valid_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pins_update: unexpected strobe got hit=%h expected none", pins_hit_out);
        end else begin
          e = exp_q.pop_front();
          if ({pins_hit_out, pins_vy_neg_out} !== e) begin
            bad++;
            $display("FAIL pins_update: got hit=%h vy=%b expected hit=%h vy=%b",
                     pins_hit_out, pins_vy_neg_out, e[10:1], e[0]);
          end
        end
      end
    end
  end

  initial begin : global_timeout
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  task automatic step();
    @(posedge clk_in); #2;
  endtask

  task automatic pulse_launch();
    ball_launch_in = 1'b1; step(); ball_launch_in = 1'b0;
  endtask

  task automatic pulse_tick();
    frame_tick_in = 1'b1; step(); frame_tick_in = 1'b0;
  endtask

  task automatic pulse_done();
    ball_done_in = 1'b1; step(); ball_done_in = 1'b0;
  endtask

  task automatic wait_valids(input int unsigned target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (valid_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Runs one frame's substeps and returns one cycle after the last strobe.
  task automatic run_frame(input logic [9:0] hit, output bit ok);
    int unsigned tgt;
    resp_hit = hit;
    tgt = valid_cnt + STEPS;
    pulse_tick();
    wait_valids(tgt, ok);
    step();
  endtask

  task automatic test_reset();
    rst_in_n = 1'b0;
    repeat (3) step();
    total++;
    if ({rst_sim_out, busy_out, coll_req_out, pins_valid_out, overrun_out, err_out} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {rst_sim_out, busy_out, coll_req_out, pins_valid_out, overrun_out, err_out});
    end
    total++;
    if (score_out !== 4'd0 || pins_hit_out !== 10'h000) begin
      bad++;
      $display("FAIL reset_data: got score=%0d hit=%h expected 0 000", score_out, pins_hit_out);
    end
    @(posedge clk_in); #3;
    rst_in_n = 1'b1;
    #1;
    total++;
    if (rst_sim_out !== 1'b1) begin
      bad++; $display("FAIL rack_on_release: got %b expected 1", rst_sim_out);
    end
    step();
    total++;
    if (rst_sim_out !== 1'b0) begin
      bad++; $display("FAIL rack_width: got %b expected 0", rst_sim_out);
    end
    total++;
    if (busy_out !== 1'b0 || score_out !== 4'd0) begin
      bad++; $display("FAIL idle_after_reset: got busy=%b score=%0d expected 0 0", busy_out, score_out);
    end
  endtask

  task automatic test_single_frame();
    int unsigned v0, h0, lat;
    bit ok;
    pulse_launch();
    total++;
    if (busy_out !== 1'b1) begin
      bad++; $display("FAIL launch_busy: got %b expected 1", busy_out);
    end
    v0 = valid_cnt; h0 = hs_cnt;
    resp_hit = 10'h003;
    pulse_tick();
    lat = 1;
    while (pins_valid_out !== 1'b1 && lat < 100) begin
      step(); lat++;
    end
    total++;
    if (lat != 2 + resp_lat) begin
      bad++; $display("FAIL tick_latency: got %0d expected %0d", lat, 2 + resp_lat);
    end
    wait_valids(v0 + STEPS, ok);
    step();
    total++;
    if (!ok || valid_cnt - v0 != STEPS || hs_cnt - h0 != STEPS) begin
      bad++; $display("FAIL frame_steps: got valids=%0d handshakes=%0d expected %0d", valid_cnt - v0, hs_cnt - h0, STEPS);
    end
    total++;
    if (pins_hit_out !== 10'h003 || busy_out !== 1'b1 || coll_req_out !== 1'b0) begin
      bad++; $display("FAIL back_to_rolling: got hit=%h busy=%b req=%b expected 003 1 0", pins_hit_out, busy_out, coll_req_out);
    end
    repeat (20) step();
    total++;
    if (valid_cnt - v0 != STEPS) begin
      bad++; $display("FAIL no_spurious_steps: got %0d expected %0d", valid_cnt - v0, STEPS);
    end
  endtask

  task automatic test_roll_end();
    int unsigned r0;
    bit ok;
    pulse_done();
    r0 = rsim_cnt;
    run_frame(10'h000, ok);
    total++;
    if (!ok || rsim_cnt != r0 || busy_out !== 1'b1) begin
      bad++; $display("FAIL settle_frame1: got ok=%b racks=%0d busy=%b expected 1 0 1", ok, rsim_cnt - r0, busy_out);
    end
    run_frame(10'h000, ok);
    total++;
    if (!ok || rst_sim_out !== 1'b1) begin
      bad++; $display("FAIL settle_exit: got ok=%b rst_sim=%b expected 1 1", ok, rst_sim_out);
    end
    step();
    total++;
    if (rst_sim_out !== 1'b0 || score_out !== 4'd2 || busy_out !== 1'b0) begin
      bad++; $display("FAIL roll1_score: got rst_sim=%b score=%0d busy=%b expected 0 2 0", rst_sim_out, score_out, busy_out);
    end
  endtask

  task automatic test_full_roll();
    int unsigned tgt;
    bit ok, all_ok;
    all_ok = 1'b1;
    pulse_launch();
    run_frame(10'h001, ok); all_ok &= ok;
    run_frame(10'h300, ok); all_ok &= ok;
    total++;
    if (!all_ok || pins_hit_out !== 10'h301) begin
      bad++; $display("FAIL sticky_mask: got ok=%b hit=%h expected 1 301", all_ok, pins_hit_out);
    end
    resp_hit = 10'h000;
    tgt = valid_cnt + STEPS;
    frame_tick_in = 1'b1; ball_done_in = 1'b1;
    step();
    frame_tick_in = 1'b0; ball_done_in = 1'b0;
    wait_valids(tgt, ok);
    step();
    total++;
    if (!ok || busy_out !== 1'b1 || rst_sim_out !== 1'b0) begin
      bad++; $display("FAIL tick_with_done: got ok=%b busy=%b rst_sim=%b expected 1 1 0", ok, busy_out, rst_sim_out);
    end
    run_frame(10'h000, ok);
    total++;
    if (!ok || rst_sim_out !== 1'b0) begin
      bad++; $display("FAIL early_rack: got ok=%b rst_sim=%b expected 1 0", ok, rst_sim_out);
    end
    run_frame(10'h000, ok);
    total++;
    if (!ok || rst_sim_out !== 1'b1) begin
      bad++; $display("FAIL roll2_rack: got ok=%b rst_sim=%b expected 1 1", ok, rst_sim_out);
    end
    step();
    total++;
    if (score_out !== 4'd3 || busy_out !== 1'b0) begin
      bad++; $display("FAIL roll2_score: got score=%0d busy=%b expected 3 0", score_out, busy_out);
    end
  endtask

  task automatic test_overrun();
    int unsigned v0, o0, exp_v, exp_o;
    bit ok;
`ifdef PIN_SEQ_TICK_QUEUE_EN
    exp_v = 2 * STEPS; exp_o = 0;
`else
    exp_v = STEPS; exp_o = 1;
`endif
    pulse_launch();
    v0 = valid_cnt; o0 = ovr_cnt;
    resp_hit = 10'h0F0;
    pulse_tick();
    wait_valids(v0 + 1, ok);
    pulse_tick();
    wait_valids(v0 + exp_v, ok);
    repeat (30) step();
    total++;
    if (!ok || valid_cnt - v0 != exp_v) begin
      bad++; $display("FAIL overrun_steps: got %0d expected %0d", valid_cnt - v0, exp_v);
    end
    total++;
    if (ovr_cnt - o0 != exp_o) begin
      bad++; $display("FAIL overrun_pulse: got %0d expected %0d", ovr_cnt - o0, exp_o);
    end
  endtask

  task automatic test_watchdog();
    int unsigned n;
    resp_en = 1'b0;
    pulse_tick();
    n = 0;
    while (coll_req_out === 1'b1 && n < 200) begin
      n++; step();
    end
    total++;
    if (n != WD) begin
      bad++; $display("FAIL watchdog_cycles: got %0d expected %0d", n, WD);
    end
    total++;
    if (rst_sim_out !== 1'b1 || err_out !== 1'b1) begin
      bad++; $display("FAIL watchdog_abort: got rst_sim=%b err=%b expected 1 1", rst_sim_out, err_out);
    end
    step();
    total++;
    if (score_out !== 4'd0 || busy_out !== 1'b0 || err_out !== 1'b1) begin
      bad++; $display("FAIL abort_score: got score=%0d busy=%b err=%b expected 0 0 1", score_out, busy_out, err_out);
    end
    resp_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    resp_en = 1'b0;
    pulse_launch();
    pulse_tick();
    repeat (3) step();
    total++;
    if (coll_req_out !== 1'b1) begin
      bad++; $display("FAIL mid_req: got %b expected 1", coll_req_out);
    end
    rst_in_n = 1'b0;
    #1;
    total++;
    if ({coll_req_out, busy_out, rst_sim_out, pins_valid_out, err_out, overrun_out} !== 6'b0 || score_out !== 4'd0) begin
      bad++; $display("FAIL mid_reset_outputs: got %b score=%0d expected 000000 0",
                      {coll_req_out, busy_out, rst_sim_out, pins_valid_out, err_out, overrun_out}, score_out);
    end
    step(); step();
    #1;
    rst_in_n = 1'b1;
    #1;
    total++;
    if (rst_sim_out !== 1'b1) begin
      bad++; $display("FAIL mid_release_rack: got %b expected 1", rst_sim_out);
    end
    step();
    total++;
    if (rst_sim_out !== 1'b0 || busy_out !== 1'b0) begin
      bad++; $display("FAIL mid_release_idle: got rst_sim=%b busy=%b expected 0 0", rst_sim_out, busy_out);
    end
    exp_q.delete();
    model_sticky = '0;
    resp_en = 1'b1;
  endtask

  initial begin : main
    rst_in_n       = 1'b0;
    frame_tick_in  = 1'b0;
    ball_launch_in = 1'b0;
    ball_done_in   = 1'b0;
    test_reset();
    test_single_frame();
    test_roll_end();
    test_full_roll();
    test_overrun();
    test_watchdog();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
